// File: rtl/sha256_stream_padder.sv
// Packs a 32-bit big-endian message stream into FIPS 180-4 padded 512-bit blocks
// and sequences the SHA-256 core. Define SHA_PAD_KEEP_CHECK_EN to flag illegal last-beat keep.
module sha256_stream_padder #(
  parameter int unsigned LEN_W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [31:0]  s_tdata,
  input  logic [3:0]   s_tkeep,
  input  logic         s_tlast,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [511:0] core_block,
  output logic         core_init,
  output logic         core_next,
  input  logic         core_ready,
  input  logic         core_digest_valid,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam logic [IDX_W-1:0] IDX_13 = IDX_W'(13);
  localparam logic [IDX_W-1:0] IDX_14 = IDX_W'(14);
  localparam logic [IDX_W-1:0] IDX_15 = IDX_W'(15);
  localparam logic [IDX_W-1:0] IDX_16 = IDX_W'(16);

  typedef enum logic [2:0] {IDLE, FILL, PAD, LEN_HI, LEN_LO, ISSUE, WAIT, FIN} state_t;

  state_t           state;
  state_t           ret;
  logic [IDX_W-1:0] widx;
  logic [LEN_W-1:0] byte_count;
  logic             first;
  logic             pend80;
  logic             seen_low;

  logic             beat_c;
  logic [2:0]       keep_k_c;
  logic [31:0]      last_word_c;
  logic [8:0]       wsel_c;
  logic [63:0]      bit_len_c;
  logic             unused_digest;

  // Digest valid is informational; sequencing relies on core_ready alone.
  assign unused_digest = core_digest_valid;

  assign beat_c    = s_tvalid && s_tready && (state == IDLE || state == FILL);
  assign wsel_c    = {4'd15 - widx[3:0], 5'd0};
  assign bit_len_c = 64'({byte_count, 3'b000});

`ifdef SHA_PAD_KEEP_CHECK_EN
  logic keep_bad_c;
`endif

  // Valid-byte count on the last beat: leading ones of keep from bit 3.
  always_comb begin
    if (!s_tkeep[3])      keep_k_c = 3'd0;
    else if (!s_tkeep[2]) keep_k_c = 3'd1;
    else if (!s_tkeep[1]) keep_k_c = 3'd2;
    else if (!s_tkeep[0]) keep_k_c = 3'd3;
    else                  keep_k_c = 3'd4;
`ifdef SHA_PAD_KEEP_CHECK_EN
    keep_bad_c = !(s_tkeep inside {4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111});
    if (keep_bad_c) keep_k_c = 3'd4;
`endif
  end

  // Partial last word: data bytes, then the 0x80 marker, then zeros.
  always_comb begin
    last_word_c = s_tdata;
    case (keep_k_c)
      3'd0:    last_word_c = 32'h8000_0000;
      3'd1:    last_word_c = {s_tdata[31:24], 24'h80_0000};
      3'd2:    last_word_c = {s_tdata[31:16], 16'h8000};
      3'd3:    last_word_c = {s_tdata[31:8], 8'h80};
      default: last_word_c = s_tdata;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      ret        <= IDLE;
      widx       <= '0;
      byte_count <= '0;
      first      <= 1'b1;
      pend80     <= 1'b0;
      seen_low   <= 1'b0;
      core_block <= '0;
      core_init  <= 1'b0;
      core_next  <= 1'b0;
      s_tready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SHA_PAD_KEEP_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;
      s_tready  <= 1'b0;
      busy      <= 1'b1;
      case (state)
        IDLE, FILL: begin
          if (beat_c) begin
            widx <= widx + IDX_W'(1);
            if (s_tlast) begin
              byte_count                   <= byte_count + LEN_W'(keep_k_c);
              core_block[wsel_c +: WORD_W] <= last_word_c;
              pend80                       <= (keep_k_c == 3'd4);
              state                        <= PAD;
`ifdef SHA_PAD_KEEP_CHECK_EN
              if (keep_bad_c) err <= 1'b1;
`endif
            end else begin
              byte_count                   <= byte_count + LEN_W'(4);
              core_block[wsel_c +: WORD_W] <= s_tdata;
              if (widx == IDX_15) begin
                ret   <= FILL;
                state <= ISSUE;
              end else begin
                state    <= FILL;
                s_tready <= 1'b1;
              end
            end
          end else begin
            s_tready <= 1'b1;
            if (state == IDLE) busy <= 1'b0;
          end
        end
        // Marker/zero fill; a marker at word 14 or 15 spills the length into a fresh block.
        PAD: begin
          if (widx == IDX_16) begin
            ret   <= PAD;
            state <= ISSUE;
          end else if (widx == IDX_14 && !pend80) begin
            state <= LEN_HI;
          end else begin
            core_block[wsel_c +: WORD_W] <= pend80 ? 32'h8000_0000 : 32'h0;
            pend80 <= 1'b0;
            widx   <= widx + IDX_W'(1);
            if (widx == IDX_13) begin
              state <= LEN_HI;
            end else if (widx == IDX_15) begin
              ret   <= PAD;
              state <= ISSUE;
            end
          end
        end
        LEN_HI: begin
          core_block[63:32] <= bit_len_c[63:32];
          state             <= LEN_LO;
        end
        LEN_LO: begin
          core_block[31:0] <= bit_len_c[31:0];
          ret              <= FIN;
          state            <= ISSUE;
        end
        ISSUE: begin
          if (core_ready) begin
            core_init <= first;
            core_next <= !first;
            first     <= 1'b0;
            widx      <= '0;
            seen_low  <= 1'b0;
            state     <= WAIT;
          end
        end
        // Block is done once ready has dropped and come back.
        WAIT: begin
          if (!core_ready) begin
            seen_low <= 1'b1;
          end else if (seen_low) begin
            state    <= ret;
            s_tready <= (ret == FILL);
            done     <= (ret == FIN);
          end
        end
        FIN: begin
          first      <= 1'b1;
          byte_count <= '0;
          widx       <= '0;
          pend80     <= 1'b0;
          s_tready   <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SHA_PAD_KEEP_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Directed bench for sha256_stream_padder with a small behavioural SHA core model.
module tb_sha256_stream_padder;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [31:0]  s_tdata;
  logic [3:0]   s_tkeep;
  logic         s_tlast;
  logic         s_tvalid;
  logic         s_tready;
  logic [511:0] core_block;
  logic         core_init;
  logic         core_next;
  logic         core_ready;
  logic         core_digest_valid;
  logic         busy;
  logic         done;
  logic         err;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int busy_left  = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int last_acc   = 0;
  logic stall    = 1'b0;

  logic [511:0] blk_q[$];
  logic         init_q[$];
  int           pcyc_q[$];

  sha256_stream_padder dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_tdata           (s_tdata),
    .s_tkeep           (s_tkeep),
    .s_tlast           (s_tlast),
    .s_tvalid          (s_tvalid),
    .s_tready          (s_tready),
    .core_block        (core_block),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_ready        (core_ready),
    .core_digest_valid (core_digest_valid),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Core model: busy for 5 cycles after seeing a strobe.
  always @(posedge aclk) begin
    if (core_init || core_next) busy_left <= 5;
    else if (busy_left > 0)     busy_left <= busy_left - 1;
  end
  assign core_ready = !stall && (busy_left == 0);

  always @(negedge aclk) begin
    if (core_init || core_next) begin
      blk_q.push_back(core_block);
      init_q.push_back(core_init);
      pcyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [511:0] put_word(input logic [511:0] b, input int i, input logic [31:0] w);
    logic [511:0] r;
    r = b;
    r[511-32*i -: 32] = w;
    return r;
  endfunction

  task automatic clear_log();
    blk_q.delete();
    init_q.delete();
    pcyc_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (s_tready !== 1'b1 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    compared++;
    if (s_tready !== 1'b1) begin
      mismatched++;
      $display("FAIL beat_accept: s_tready=%b after %0d cycles, want 1", s_tready, n);
    end
    @(negedge aclk);
    last_acc = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge aclk);
      n++;
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    compared += 7;
    if (s_tready !== 1'b0) begin mismatched++; $display("FAIL rst_tready: got %b want 0", s_tready); end
    if (core_block !== '0) begin mismatched++; $display("FAIL rst_block: got %h want 0", core_block); end
    if (core_init !== 1'b0) begin mismatched++; $display("FAIL rst_init: got %b want 0", core_init); end
    if (core_next !== 1'b0) begin mismatched++; $display("FAIL rst_next: got %b want 0", core_next); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b want 0", done); end
    if (err !== 1'b0) begin mismatched++; $display("FAIL rst_err: got %b want 0", err); end
    aresetn = 1'b1;
    #1;
    compared++;
    if (s_tready !== 1'b0) begin mismatched++; $display("FAIL rel_tready_pre: got %b want 0", s_tready); end
    @(negedge aclk);
    compared++;
    if (s_tready !== 1'b1) begin mismatched++; $display("FAIL rel_tready_post: got %b want 1", s_tready); end
  endtask

  task automatic test_abc();
    logic [511:0] exp;
    clear_log();
    exp = '0;
    exp = put_word(exp, 0, 32'h6162_6380);
    exp = put_word(exp, 15, 32'h0000_0018);
    send_beat(32'h6162_6300, 4'b1110, 1'b1);
    wait_done(200);
    compared += 7;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL abc_done: got %0d want 1", done_cnt); end
    if (blk_q.size() !== 1) begin mismatched++; $display("FAIL abc_nblk: got %0d want 1", blk_q.size()); end
    if (blk_q.size() > 0) begin
      if (init_q[0] !== 1'b1) begin mismatched++; $display("FAIL abc_init: got %b want 1", init_q[0]); end
      if (blk_q[0] !== exp) begin mismatched++; $display("FAIL abc_block: got %h want %h", blk_q[0], exp); end
      if (pcyc_q[0] !== last_acc + 16) begin mismatched++; $display("FAIL abc_issue_cyc: got %0d want %0d", pcyc_q[0], last_acc + 16); end
      if (done_cyc !== pcyc_q[0] + 7) begin mismatched++; $display("FAIL abc_done_cyc: got %0d want %0d", done_cyc, pcyc_q[0] + 7); end
    end else begin
      mismatched += 4;
      $display("FAIL abc_noblock: got 0 blocks want 1");
    end
    if (err !== 1'b0) begin mismatched++; $display("FAIL abc_err: got %b want 0", err); end
  endtask

  task automatic test_two_block();
    logic [511:0] exp0, exp1;
    clear_log();
    exp0 = '0;
    exp1 = '0;
    for (int i = 0; i < 14; i++) exp0 = put_word(exp0, i, 32'hC0DE_0000 + 32'(i));
    exp0 = put_word(exp0, 14, 32'h8000_0000);
    exp1 = put_word(exp1, 15, 32'h0000_01C0);
    for (int i = 0; i < 14; i++) send_beat(32'hC0DE_0000 + 32'(i), 4'b1111, (i == 13));
    wait_done(300);
    compared += 2;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL b56_done: got %0d want 1", done_cnt); end
    if (blk_q.size() !== 2) begin mismatched++; $display("FAIL b56_nblk: got %0d want 2", blk_q.size()); end
    if (blk_q.size() >= 2) begin
      compared += 4;
      if (init_q[0] !== 1'b1) begin mismatched++; $display("FAIL b56_init0: got %b want 1", init_q[0]); end
      if (blk_q[0] !== exp0) begin mismatched++; $display("FAIL b56_blk0: got %h want %h", blk_q[0], exp0); end
      if (init_q[1] !== 1'b0) begin mismatched++; $display("FAIL b56_next1: got init=%b want 0", init_q[1]); end
      if (blk_q[1] !== exp1) begin mismatched++; $display("FAIL b56_blk1: got %h want %h", blk_q[1], exp1); end
    end
  endtask

  task automatic test_stream_boundary();
    logic [511:0] exp0, exp1;
    int p;
    clear_log();
    exp0 = '0;
    exp1 = '0;
    for (int i = 0; i < 16; i++) exp0 = put_word(exp0, i, 32'h5A00_0000 + 32'(i * 3));
    exp1 = put_word(exp1, 0, 32'h8000_0000);
    exp1 = put_word(exp1, 15, 32'h0000_0200);
    for (int i = 0; i < 16; i++) send_beat(32'h5A00_0000 + 32'(i * 3), 4'b0101, 1'b0);
    compared++;
    if (s_tready !== 1'b0) begin mismatched++; $display("FAIL b64_tready_low: got %b want 0", s_tready); end
    send_beat(32'hDEAD_BEEF, 4'b0000, 1'b1);
    compared++;
    if (pcyc_q.size() !== 1) begin
      mismatched++;
      $display("FAIL b64_midissue: got %0d blocks before last beat want 1", pcyc_q.size());
    end else begin
      p = pcyc_q[0];
      compared++;
      if (last_acc !== p + 8) begin mismatched++; $display("FAIL b64_resume_cyc: got %0d want %0d", last_acc, p + 8); end
    end
    wait_done(300);
    compared += 2;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL b64_done: got %0d want 1", done_cnt); end
    if (blk_q.size() !== 2) begin mismatched++; $display("FAIL b64_nblk: got %0d want 2", blk_q.size()); end
    if (blk_q.size() >= 2) begin
      compared += 4;
      if (init_q[0] !== 1'b1) begin mismatched++; $display("FAIL b64_init0: got %b want 1", init_q[0]); end
      if (blk_q[0] !== exp0) begin mismatched++; $display("FAIL b64_blk0: got %h want %h", blk_q[0], exp0); end
      if (init_q[1] !== 1'b0) begin mismatched++; $display("FAIL b64_next1: got init=%b want 0", init_q[1]); end
      if (blk_q[1] !== exp1) begin mismatched++; $display("FAIL b64_blk1: got %h want %h", blk_q[1], exp1); end
    end
  endtask

  task automatic test_core_stall();
    logic [511:0] exp;
    int rel;
    clear_log();
    exp = '0;
    exp = put_word(exp, 0, 32'h4142_8000);
    exp = put_word(exp, 15, 32'h0000_0010);
    stall = 1'b1;
    send_beat(32'h4142_9999, 4'b1100, 1'b1);
    repeat (66) @(negedge aclk);
    compared += 3;
    if (blk_q.size() !== 0) begin mismatched++; $display("FAIL stall_nostrobe: got %0d strobes want 0", blk_q.size()); end
    if (core_block !== exp) begin mismatched++; $display("FAIL stall_block: got %h want %h", core_block, exp); end
    if (busy !== 1'b1) begin mismatched++; $display("FAIL stall_busy: got %b want 1", busy); end
    stall = 1'b0;
    rel = cyc;
    wait_done(200);
    compared += 2;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
    if (pcyc_q.size() !== 1) begin
      mismatched++;
      $display("FAIL stall_nblk: got %0d want 1", pcyc_q.size());
    end else begin
      compared += 2;
      if (pcyc_q[0] !== rel + 1) begin mismatched++; $display("FAIL stall_strobe_cyc: got %0d want %0d", pcyc_q[0], rel + 1); end
      if (blk_q[0] !== exp) begin mismatched++; $display("FAIL stall_blk: got %h want %h", blk_q[0], exp); end
    end
  endtask

  task automatic test_reset_mid_pad();
    logic [511:0] exp;
    clear_log();
    exp = '0;
    exp = put_word(exp, 0, 32'h6162_6380);
    exp = put_word(exp, 15, 32'h0000_0018);
    send_beat(32'h6162_6300, 4'b1110, 1'b1);
    repeat (4) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    compared += 6;
    if (s_tready !== 1'b0) begin mismatched++; $display("FAIL mid_tready: got %b want 0", s_tready); end
    if (core_block !== '0) begin mismatched++; $display("FAIL mid_block: got %h want 0", core_block); end
    if (core_init !== 1'b0 || core_next !== 1'b0) begin mismatched++; $display("FAIL mid_strobe: got %b%b want 00", core_init, core_next); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin mismatched++; $display("FAIL mid_done: got %b want 0", done); end
    if (err !== 1'b0) begin mismatched++; $display("FAIL mid_err: got %b want 0", err); end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    clear_log();
    send_beat(32'h6162_6300, 4'b1110, 1'b1);
    wait_done(200);
    compared += 2;
    if (done_cnt !== 1) begin mismatched++; $display("FAIL mid_redo_done: got %0d want 1", done_cnt); end
    if (blk_q.size() !== 1) begin
      mismatched++;
      $display("FAIL mid_redo_nblk: got %0d want 1", blk_q.size());
    end else begin
      compared += 2;
      if (init_q[0] !== 1'b1) begin mismatched++; $display("FAIL mid_redo_init: got %b want 1", init_q[0]); end
      if (blk_q[0] !== exp) begin mismatched++; $display("FAIL mid_redo_blk: got %h want %h", blk_q[0], exp); end
    end
  endtask

  task automatic test_keep();
    logic [511:0] exp;
    logic         exp_err;
    clear_log();
    exp = '0;
`ifdef SHA_PAD_KEEP_CHECK_EN
    exp = put_word(exp, 0, 32'h1122_3344);
    exp = put_word(exp, 1, 32'h8000_0000);
    exp = put_word(exp, 15, 32'h0000_0020);
    exp_err = 1'b1;
`else
    exp = put_word(exp, 0, 32'h1180_0000);
    exp = put_word(exp, 15, 32'h0000_0008);
    exp_err = 1'b0;
`endif
    send_beat(32'h1122_3344, 4'b1010, 1'b1);
    wait_done(200);
    compared += 3;
    if (err !== exp_err) begin mismatched++; $display("FAIL keep_err: got %b want %b", err, exp_err); end
    if (done_cnt !== 1) begin mismatched++; $display("FAIL keep_done: got %0d want 1", done_cnt); end
    if (blk_q.size() !== 1) begin
      mismatched++;
      $display("FAIL keep_nblk: got %0d want 1", blk_q.size());
    end else begin
      compared++;
      if (blk_q[0] !== exp) begin mismatched++; $display("FAIL keep_blk: got %h want %h", blk_q[0], exp); end
    end
  endtask

  initial begin
    aresetn           = 1'b0;
    s_tdata           = '0;
    s_tkeep           = '0;
    s_tlast           = 1'b0;
    s_tvalid          = 1'b0;
    core_digest_valid = 1'b0;
    test_reset();
    test_abc();
    test_two_block();
    test_stream_boundary();
    test_core_stall();
    test_reset_mid_pad();
    test_keep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
